// File: rtl/aip_irq_pkg.sv
// Shared types and constants for the aipStatus interrupt scheduler.
//   state_e      : scheduler FSM states
//   NUM_SRC      : interrupt flags serviced (fixed by the status register layout)
//   SRC_ID_W     : width of a source index
//   *_LSB        : field offsets inside the 32-bit status word
//   src_onehot() : index -> clear mask
package aip_irq_pkg;

   localparam int unsigned NUM_SRC  = 8;
   localparam int unsigned SRC_ID_W = $clog2(NUM_SRC);

   localparam int unsigned INT_LSB  = 0;
   localparam int unsigned STAT_LSB = 8;
   localparam int unsigned MASK_LSB = 16;

   typedef enum logic [1:0] {
      StIdle,
      StPresent,
      StClear,
      StSettle
   } state_e;

   function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_ID_W-1:0] id);
      return NUM_SRC'(1) << id;
   endfunction

endpackage

// File: rtl/aip_irq_scheduler_if.sv
// Bundle between the scheduler, the status register and the host.
//   slave  : scheduler side (drives write port, irq presentation, cfg_ready)
//   master : environment side (drives readback, enable, ack, cfg request)
interface aip_irq_scheduler_if
   import aip_irq_pkg::*;
   ();

   logic                enable;
   logic [31:0]         data_status;
   logic                en_set;
   logic [31:0]         data_in;
   logic                irq_valid;
   logic [SRC_ID_W-1:0] irq_id;
   logic                irq_ack;
   logic                irq_timeout;
   logic                cfg_wr;
   logic [31:0]         cfg_data;
   logic                cfg_ready;

   modport slave (
      input  enable, data_status, irq_ack, cfg_wr, cfg_data,
      output en_set, data_in, irq_valid, irq_id, irq_timeout, cfg_ready
   );

   modport master (
      output enable, data_status, irq_ack, cfg_wr, cfg_data,
      input  en_set, data_in, irq_valid, irq_id, irq_timeout, cfg_ready
   );

endinterface

// File: rtl/aip_rr_pick.sv
// Round-robin picker: first set bit of req_i scanning upward from ptr_i+1, modulo NUM_SRC.
//   req_i    : request vector
//   ptr_i    : index of the last source served
//   gnt_id_o : selected index (meaningful only when any_o)
//   any_o    : at least one request set
module aip_rr_pick #(
   parameter int unsigned NUM_SRC = 8
) (
   input  logic [NUM_SRC-1:0]         req_i,
   input  logic [$clog2(NUM_SRC)-1:0] ptr_i,
   output logic [$clog2(NUM_SRC)-1:0] gnt_id_o,
   output logic                       any_o
);

   localparam int unsigned IdW = $clog2(NUM_SRC);

   logic [2*NUM_SRC-1:0] dbl;
   logic [NUM_SRC-1:0]   rot;
   int                   off;

   always_comb begin
      // Rotate so that bit 0 of rot is source ptr_i+1, then find the lowest set bit.
      dbl = {req_i, req_i} >> (int'(ptr_i) + 1);
      rot = dbl[NUM_SRC-1:0];
      off = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (rot[i]) off = i;
      end
      gnt_id_o = IdW'((int'(ptr_i) + 1 + off) % NUM_SRC);
      any_o    = |req_i;
   end

endmodule

// File: rtl/aip_irq_scheduler.sv
// Interrupt scheduler for the aipStatus register: presents one pending, unmasked flag at a time
// (round-robin), issues the clear write on ack, skips a source after ACK_TIMEOUT cycles without
// ack, and shares the register's single write port with host config writes.
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : status readback/write port, irq presentation/ack, host cfg write channel
module aip_irq_scheduler
   import aip_irq_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 64,
   parameter int unsigned TMR_W       = 7
) (
   input logic                  clk,
   input logic                  rst,
   aip_irq_scheduler_if.slave   bus_io
);

   localparam logic [TMR_W-1:0] TmrLast = TMR_W'(ACK_TIMEOUT - 1);

   state_e              state_q;
   logic [SRC_ID_W-1:0] ptr_q;
   logic [TMR_W-1:0]    timer_q;
   logic                irq_valid_q;
   logic [SRC_ID_W-1:0] irq_id_q;
   logic                irq_timeout_q;

   logic [NUM_SRC-1:0]  pending;
   logic [SRC_ID_W-1:0] pick_id;
   logic                pick_any;
   logic                cfg_ready;

   assign pending = bus_io.data_status[INT_LSB +: NUM_SRC] & bus_io.data_status[MASK_LSB +: NUM_SRC];

   aip_rr_pick #(
      .NUM_SRC (NUM_SRC)
   ) u_pick (
      .req_i    (pending),
      .ptr_i    (ptr_q),
      .gnt_id_o (pick_id),
      .any_o    (pick_any)
   );

   // The clear write owns the port in StClear; host writes are accepted everywhere else.
   assign cfg_ready = bus_io.cfg_wr && !rst && (state_q != StClear);

   always_comb begin
      bus_io.en_set  = 1'b0;
      bus_io.data_in = '0;
      if (!rst && state_q == StClear) begin
         bus_io.en_set                          = 1'b1;
         // Re-sample the mask so the clear write does not disturb it.
         bus_io.data_in[MASK_LSB +: NUM_SRC]    = bus_io.data_status[MASK_LSB +: NUM_SRC];
         bus_io.data_in[INT_LSB +: NUM_SRC]     = src_onehot(irq_id_q);
      end else if (cfg_ready) begin
         bus_io.en_set  = 1'b1;
         bus_io.data_in = bus_io.cfg_data;
      end
   end

   assign bus_io.cfg_ready   = cfg_ready;
   assign bus_io.irq_valid   = irq_valid_q;
   assign bus_io.irq_id      = irq_id_q;
   assign bus_io.irq_timeout = irq_timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         ptr_q         <= SRC_ID_W'(NUM_SRC - 1);
         timer_q       <= '0;
         irq_valid_q   <= 1'b0;
         irq_id_q      <= '0;
         irq_timeout_q <= 1'b0;
      end else begin
         irq_timeout_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // A host write this cycle blocks arbitration; retry next cycle.
               if (bus_io.enable && pick_any && !cfg_ready) begin
                  irq_id_q    <= pick_id;
                  timer_q     <= '0;
                  irq_valid_q <= 1'b1;
                  state_q     <= StPresent;
               end
            end
            StPresent: begin
               if (bus_io.irq_ack) begin
                  ptr_q       <= irq_id_q;
                  irq_valid_q <= 1'b0;
                  state_q     <= StClear;
               end else if (!pending[irq_id_q]) begin
                  // Flag cleared behind our back by a host write: drop silently.
                  irq_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end else if (timer_q == TmrLast) begin
                  irq_timeout_q <= 1'b1;
                  ptr_q         <= irq_id_q;
                  irq_valid_q   <= 1'b0;
                  state_q       <= StIdle;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StClear:  state_q <= StSettle;
            StSettle: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_aip_irq_scheduler.sv
module tb_aip_irq_scheduler;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   aip_irq_scheduler_if bus ();

   aip_irq_scheduler #(
      .ACK_TIMEOUT (4),
      .TMR_W       (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   // Behavioural model of the status register: flags/mask, written through en_set/data_in.
   logic       load;
   logic [7:0] load_flags;
   logic [7:0] load_mask;
   logic [7:0] flags_r = 8'h00;
   logic [7:0] mask_r  = 8'h00;
   int         en_cnt  = 0;

   assign bus.data_status = {8'h00, mask_r, 8'hA5, flags_r};

   always @(posedge clk) begin
      if (bus.en_set) en_cnt <= en_cnt + 1;
      if (load) begin
         flags_r <= load_flags;
         mask_r  <= load_mask;
      end else if (bus.en_set) begin
         flags_r <= flags_r & ~bus.data_in[7:0];
         mask_r  <= bus.data_in[23:16];
      end
   end

   int errs   = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_reg(input logic [7:0] f, input logic [7:0] m);
      load_flags = f;
      load_mask  = m;
      load       = 1'b1;
      step();
      load       = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.irq_valid && cyc < 20) begin
         step();
         cyc++;
      end
      check_eq("valid_wait", 32'(bus.irq_valid), 32'd1);
   endtask

   // Ack the presented source; expect exactly one clear write carrying exp_din.
   task automatic ack_and_clear(input logic [31:0] exp_din);
      int cnt0;
      cnt0        = en_cnt;
      bus.irq_ack = 1'b1;
      #1;
      check_eq("present_no_enset", 32'(bus.en_set), 32'd0);
      step();
      bus.irq_ack = 1'b0;
      #1;
      check_eq("clear_enset", 32'(bus.en_set), 32'd1);
      check_eq("clear_data", bus.data_in, exp_din);
      check_eq("clear_cfgready", 32'(bus.cfg_ready), 32'd0);
      step();
      check_eq("one_write_per_ack", 32'(en_cnt), 32'(cnt0 + 1));
      check_eq("settle_enset", 32'(bus.en_set), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int k;
      int cnt0;
      int vcnt;

      // Reset with host write request and all flags pending.
      rst          = 1'b1;
      bus.enable   = 1'b1;
      bus.cfg_wr   = 1'b1;
      bus.cfg_data = 32'hDEADBEEF;
      bus.irq_ack  = 1'b0;
      load_flags   = 8'hFF;
      load_mask    = 8'hFF;
      load         = 1'b1;
      repeat (2) begin
         step();
         check_eq("rst_enset", 32'(bus.en_set), 32'd0);
         check_eq("rst_datain", bus.data_in, 32'd0);
         check_eq("rst_valid", 32'(bus.irq_valid), 32'd0);
         check_eq("rst_id", 32'(bus.irq_id), 32'd0);
         check_eq("rst_timeout", 32'(bus.irq_timeout), 32'd0);
         check_eq("rst_cfgready", 32'(bus.cfg_ready), 32'd0);
      end
      rst        = 1'b0;
      bus.cfg_wr = 1'b0;
      bus.enable = 1'b0;
      load_flags = 8'h05;
      load_mask  = 8'hFF;
      check_eq("rst_no_writes", 32'(en_cnt), 32'd0);
      step();
      load       = 1'b0;
      bus.enable = 1'b1;

      // Round-robin 0 -> 2 -> 0.
      wait_valid(cyc);
      check_eq("present_latency", 32'(cyc), 32'd1);
      check_eq("rr_id0", 32'(bus.irq_id), 32'd0);
      ack_and_clear(32'h00FF0001);
      wait_valid(cyc);
      check_eq("rr_id2", 32'(bus.irq_id), 32'd2);
      ack_and_clear(32'h00FF0004);
      load_reg(8'h01, 8'hFF);
      wait_valid(cyc);
      check_eq("rr_id0_again", 32'(bus.irq_id), 32'd0);
      ack_and_clear(32'h00FF0001);

      // Masking.
      load_reg(8'h0F, 8'h08);
      wait_valid(cyc);
      check_eq("mask_id3", 32'(bus.irq_id), 32'd3);
      ack_and_clear(32'h00080008);
      load_reg(8'h0F, 8'h00);
      vcnt = 0;
      repeat (10) begin
         step();
         if (bus.irq_valid) vcnt++;
      end
      check_eq("mask_zero_no_valid", 32'(vcnt), 32'd0);

      // Ack timeout: ptr=3, pending 03 -> 0 presented, skipped, then 1.
      load_reg(8'h03, 8'hFF);
      wait_valid(cyc);
      check_eq("to_first_id", 32'(bus.irq_id), 32'd0);
      cnt0 = en_cnt;
      k = 0;
      while (!bus.irq_timeout && k < 10) begin
         step();
         k++;
      end
      check_eq("to_delay", 32'(k), 32'd4);
      check_eq("to_valid_low", 32'(bus.irq_valid), 32'd0);
      step();
      check_eq("to_pulse_once", 32'(bus.irq_timeout), 32'd0);
      check_eq("to_next_valid", 32'(bus.irq_valid), 32'd1);
      check_eq("to_next_id", 32'(bus.irq_id), 32'd1);
      check_eq("to_no_write", 32'(en_cnt), 32'(cnt0));
      ack_and_clear(32'h00FF0002);

      // Write-port conflict: host write held through CLEAR.
      wait_valid(cyc);
      check_eq("wp_id0", 32'(bus.irq_id), 32'd0);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack  = 1'b0;
      bus.cfg_wr   = 1'b1;
      bus.cfg_data = 32'h00FF0000;
      #1;
      check_eq("wp_clear_cfgready", 32'(bus.cfg_ready), 32'd0);
      check_eq("wp_clear_enset", 32'(bus.en_set), 32'd1);
      check_eq("wp_clear_data", bus.data_in, 32'h00FF0001);
      step();
      check_eq("wp_next_cfgready", 32'(bus.cfg_ready), 32'd1);
      check_eq("wp_next_enset", 32'(bus.en_set), 32'd1);
      check_eq("wp_next_data", bus.data_in, 32'h00FF0000);
      bus.cfg_wr = 1'b0;

      // Flag cleared by host while presented.
      load_reg(8'h04, 8'hFF);
      wait_valid(cyc);
      check_eq("cu_id2", 32'(bus.irq_id), 32'd2);
      bus.cfg_wr   = 1'b1;
      bus.cfg_data = 32'h00FF0004;
      #1;
      check_eq("cu_cfgready", 32'(bus.cfg_ready), 32'd1);
      check_eq("cu_enset", 32'(bus.en_set), 32'd1);
      check_eq("cu_data", bus.data_in, 32'h00FF0004);
      step();
      bus.cfg_wr = 1'b0;
      check_eq("cu_still_valid", 32'(bus.irq_valid), 32'd1);
      step();
      check_eq("cu_dropped", 32'(bus.irq_valid), 32'd0);
      check_eq("cu_no_timeout", 32'(bus.irq_timeout), 32'd0);
      cnt0        = en_cnt;
      bus.irq_ack = 1'b1;
      step();
      step();
      bus.irq_ack = 1'b0;
      check_eq("cu_late_ack_valid", 32'(bus.irq_valid), 32'd0);
      check_eq("cu_late_ack_nowrite", 32'(en_cnt), 32'(cnt0));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
